spi_sts_sync: RTL

- Returns status from the SPI clock domain into the AXI clock domain; the reverse path of the config synchronizer that feeds the SPI side.
- Receiving end of a toggle req/ack handshake. The SPI-side sender holds a status bundle, flips spi_req_tgl, and keeps the bundle stable until spi_ack_tgl matches.
- Single clock (AXI clk). All spi_* inputs are asynchronous to it.
- Adds a glitch-guard double sample, sticky fault latching with write-1-to-clear, and a staleness watchdog for axi_shim status registers.

---
 rtl/spi_sts_sync.sv | 132 +++++++++++++
 1 files changed

// File: rtl/spi_sts_sync.sv
// Receiving end of the SPI->AXI status toggle handshake: synchronizes the request, double-samples
// the status bus, latches sticky faults and flags staleness. Optional update_cnt via SPI_STS_SYNC_UPDATE_CNT_EN.
module spi_sts_sync #(
  parameter int DEPTH        = 3,
  parameter int MAX_RETRY    = 4,
  parameter int STALE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] spi_trig_count,
  input  logic        spi_running,
  input  logic [7:0]  spi_fault,
  input  logic        spi_req_tgl,
  output logic        spi_ack_tgl,
  input  logic [7:0]  fault_clr,
  output logic [31:0] trig_count_stable,
  output logic        running_stable,
  output logic [7:0]  fault_sticky,
  output logic        sts_valid,
  output logic        sts_err,
`ifdef SPI_STS_SYNC_UPDATE_CNT_EN
  output logic [15:0] update_cnt,
`endif
  output logic        sts_stale
);

  localparam int SW = (STALE_CYCLES > 0) ? $clog2(STALE_CYCLES + 1) : 1;
  localparam logic [SW-1:0] STALE_MAX  = SW'(STALE_CYCLES);
  localparam logic [3:0]    RETRY_LAST = 4'(MAX_RETRY - 1);

  typedef enum logic [1:0] {IDLE, SAMPLE, VERIFY} state_t;

  state_t          state_reg;
  logic [DEPTH-1:0] sync_reg;
  logic [40:0]     shadow_reg;
  logic [3:0]      retry_reg;
  logic [SW-1:0]   stale_reg;

  logic        req_s;
  logic        pending;
  logic [40:0] live;
  logic        match;
  logic        commit;
  logic        forced;

  assign req_s   = sync_reg[DEPTH-1];
  assign pending = req_s != spi_ack_tgl;
  assign live    = {spi_trig_count, spi_running, spi_fault};
  assign match   = shadow_reg == live;
  assign commit  = (state_reg == VERIFY) && (match || retry_reg == RETRY_LAST);
  assign forced  = (state_reg == VERIFY) && !match && retry_reg == RETRY_LAST;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[DEPTH-2:0], spi_req_tgl};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg         <= IDLE;
      shadow_reg        <= '0;
      retry_reg         <= '0;
      spi_ack_tgl       <= 1'b0;
      trig_count_stable <= '0;
      running_stable    <= 1'b0;
      sts_valid         <= 1'b0;
      sts_err           <= 1'b0;
    end else begin
      sts_valid <= commit;
      if (forced) sts_err <= 1'b1;
      if (commit) begin
        trig_count_stable <= shadow_reg[40:9];
        running_stable    <= shadow_reg[8];
        spi_ack_tgl       <= ~spi_ack_tgl;
      end
      case (state_reg)
        IDLE: begin
          if (pending) state_reg <= SAMPLE;
        end
        SAMPLE: begin
          shadow_reg <= live;
          state_reg  <= VERIFY;
        end
        VERIFY: begin
          if (commit) begin
            retry_reg <= '0;
            state_reg <= IDLE;
          end else begin
            retry_reg <= retry_reg + 4'd1;
            state_reg <= SAMPLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // A set arriving with a clear on the same bit wins, so no fault is ever lost.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fault_sticky <= '0;
    end else begin
      fault_sticky <= (fault_sticky & ~fault_clr) | (commit ? shadow_reg[7:0] : 8'h00);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stale_reg <= '0;
    end else if (commit) begin
      stale_reg <= '0;
    end else if (stale_reg != STALE_MAX) begin
      stale_reg <= stale_reg + 1'b1;
    end
  end

  assign sts_stale = (STALE_CYCLES != 0) && (stale_reg == STALE_MAX);

`ifdef SPI_STS_SYNC_UPDATE_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      update_cnt <= '0;
    end else if (commit) begin
      update_cnt <= update_cnt + 16'd1;
    end
  end
`endif

endmodule
